// File: rtl/br_arbiter_pkg.sv
// Shared types and defaults for the PSRAM burst-RAM command-port arbiter.
package br_arbiter_pkg;

  localparam int unsigned BR_DATA_BITWIDTH          = 64;
  localparam int unsigned BR_MASK_BITWIDTH          = 8;
  localparam int unsigned BR_DEFAULT_BURST_BEATS    = 4;
  localparam int unsigned BR_DEFAULT_CMD_GAP_CYCLES = 8;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StGap
  } br_state_e;

endpackage

// File: rtl/br_arbiter_pick.sv
// Combinational 2-way request picker; prio names the port that wins a tie.
module br_arbiter_pick (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = prio ? req[1] : ~req[0];
  end

endmodule

// File: rtl/br_arbiter.sv
// Two-port burst arbiter for the PSRAM br_* command port (br_clk_out domain).
// Define BR_ARBITER_ROUND_ROBIN_EN for round-robin priority; default is fixed (port 0 wins).
module br_arbiter
  import br_arbiter_pkg::*;
#(
  parameter int unsigned AddressBitWidth   = 21,
  parameter int unsigned BurstBeats        = BR_DEFAULT_BURST_BEATS,
  parameter int unsigned CmdGapCycles      = BR_DEFAULT_CMD_GAP_CYCLES,
  parameter int unsigned ReadTimeoutCycles = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        m0_req,
  input  logic                        m1_req,
  input  logic                        m0_we,
  input  logic                        m1_we,
  input  logic [AddressBitWidth-1:0]  m0_addr,
  input  logic [AddressBitWidth-1:0]  m1_addr,
  input  logic [BR_DATA_BITWIDTH-1:0] m0_wr_data,
  input  logic [BR_DATA_BITWIDTH-1:0] m1_wr_data,
  input  logic [BR_MASK_BITWIDTH-1:0] m0_wr_mask,
  input  logic [BR_MASK_BITWIDTH-1:0] m1_wr_mask,
  output logic                        m0_grant,
  output logic                        m1_grant,
  output logic                        m0_wr_ack,
  output logic                        m1_wr_ack,
  output logic                        m0_rd_valid,
  output logic                        m1_rd_valid,
  output logic [BR_DATA_BITWIDTH-1:0] rd_data,
  output logic                        m0_done,
  output logic                        m1_done,
  output logic                        rd_timeout,
  output logic                        br_cmd,
  output logic                        br_cmd_en,
  output logic [AddressBitWidth-1:0]  br_addr,
  output logic [BR_DATA_BITWIDTH-1:0] br_wr_data,
  output logic [BR_MASK_BITWIDTH-1:0] br_data_mask,
  input  logic [BR_DATA_BITWIDTH-1:0] br_rd_data,
  input  logic                        br_rd_data_valid
);

  localparam int unsigned BeatW  = $clog2(BurstBeats) + 1;
  localparam int unsigned GapW   = $clog2(CmdGapCycles + 1);
  localparam int unsigned TimerW = $clog2(ReadTimeoutCycles + 1);

  localparam logic [BeatW-1:0]  LastBeat = BeatW'(BurstBeats - 1);
  localparam logic [GapW-1:0]   GapEnd   = GapW'(CmdGapCycles);
  localparam logic [TimerW-1:0] TimerEnd = TimerW'(ReadTimeoutCycles - 1);

  br_state_e         state_q;
  logic              owner_q;
  logic [BeatW-1:0]  beat_cnt_q;
  logic [GapW-1:0]   gap_cnt_q;
  logic [TimerW-1:0] timer_q;

  logic                        prio;
  logic                        win;
  logic                        win_valid;
  logic                        win_we;
  logic [AddressBitWidth-1:0]  win_addr;
  logic [BR_DATA_BITWIDTH-1:0] win_data;
  logic [BR_MASK_BITWIDTH-1:0] win_mask;
  logic [BR_DATA_BITWIDTH-1:0] own_data;
  logic [BR_MASK_BITWIDTH-1:0] own_mask;

  br_arbiter_pick u_pick (
    .req    ({m1_req, m0_req}),
    .prio   (prio),
    .winner (win),
    .valid  (win_valid)
  );

`ifdef BR_ARBITER_ROUND_ROBIN_EN
  logic prio_q;

  // After each grant the losing port gets the tie-break.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (state_q == StIdle && win_valid) begin
      prio_q <= ~win;
    end
  end

  assign prio = prio_q;
`else
  assign prio = 1'b0;
`endif

  always_comb begin
    win_we   = win ? m1_we      : m0_we;
    win_addr = win ? m1_addr    : m0_addr;
    win_data = win ? m1_wr_data : m0_wr_data;
    win_mask = win ? m1_wr_mask : m0_wr_mask;
    own_data = owner_q ? m1_wr_data : m0_wr_data;
    own_mask = owner_q ? m1_wr_mask : m0_wr_mask;
  end

  // Read data is a passthrough; only the owning port sees valid, and only in READ.
  assign rd_data     = br_rd_data;
  assign m0_rd_valid = br_rd_data_valid && (state_q == StRead) && !owner_q;
  assign m1_rd_valid = br_rd_data_valid && (state_q == StRead) && owner_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      beat_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      timer_q      <= '0;
      m0_grant     <= 1'b0;
      m1_grant     <= 1'b0;
      m0_wr_ack    <= 1'b0;
      m1_wr_ack    <= 1'b0;
      m0_done      <= 1'b0;
      m1_done      <= 1'b0;
      rd_timeout   <= 1'b0;
      br_cmd       <= 1'b0;
      br_cmd_en    <= 1'b0;
      br_addr      <= '0;
      br_wr_data   <= '0;
      br_data_mask <= '0;
    end else begin
      m0_grant   <= 1'b0;
      m1_grant   <= 1'b0;
      m0_wr_ack  <= 1'b0;
      m1_wr_ack  <= 1'b0;
      m0_done    <= 1'b0;
      m1_done    <= 1'b0;
      rd_timeout <= 1'b0;
      br_cmd_en  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            owner_q   <= win;
            m0_grant  <= ~win;
            m1_grant  <= win;
            br_cmd_en <= 1'b1;
            br_cmd    <= win_we;
            br_addr   <= win_addr;
            if (win_we) begin
              // Beat 0 goes out alongside the command.
              br_wr_data   <= win_data;
              br_data_mask <= win_mask;
              m0_wr_ack    <= ~win;
              m1_wr_ack    <= win;
              beat_cnt_q   <= BeatW'(1);
              state_q      <= StWrite;
            end else begin
              beat_cnt_q <= '0;
              timer_q    <= '0;
              state_q    <= StRead;
            end
          end
        end
        StWrite: begin
          br_wr_data   <= own_data;
          br_data_mask <= own_mask;
          m0_wr_ack    <= ~owner_q;
          m1_wr_ack    <= owner_q;
          beat_cnt_q   <= beat_cnt_q + 1'b1;
          if (beat_cnt_q == LastBeat) begin
            m0_done   <= ~owner_q;
            m1_done   <= owner_q;
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end
        end
        StRead: begin
          timer_q <= timer_q + 1'b1;
          if (br_rd_data_valid) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
          // A final beat landing on the timeout cycle still counts as a clean finish.
          if (br_rd_data_valid && beat_cnt_q == LastBeat) begin
            m0_done   <= ~owner_q;
            m1_done   <= owner_q;
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end else if (timer_q == TimerEnd) begin
            m0_done    <= ~owner_q;
            m1_done    <= owner_q;
            rd_timeout <= 1'b1;
            gap_cnt_q  <= '0;
            state_q    <= StGap;
          end
        end
        StGap: begin
          if (gap_cnt_q == GapEnd) begin
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_br_arbiter.sv
// Directed self-checking bench for br_arbiter (default fixed priority or round-robin build).
module tb_br_arbiter;

  localparam int unsigned AW = 21;

  logic          clk;
  logic          rst;
  logic          m0_req, m1_req, m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [63:0]   m0_wr_data, m1_wr_data;
  logic [7:0]    m0_wr_mask, m1_wr_mask;
  logic          m0_grant, m1_grant, m0_wr_ack, m1_wr_ack;
  logic          m0_rd_valid, m1_rd_valid, m0_done, m1_done, rd_timeout;
  logic [63:0]   rd_data;
  logic          br_cmd, br_cmd_en;
  logic [AW-1:0] br_addr;
  logic [63:0]   br_wr_data;
  logic [7:0]    br_data_mask;
  logic [63:0]   br_rd_data;
  logic          br_rd_data_valid;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [63:0] base0, base1;
  int          k0, k1;

  br_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .m0_req           (m0_req),
    .m1_req           (m1_req),
    .m0_we            (m0_we),
    .m1_we            (m1_we),
    .m0_addr          (m0_addr),
    .m1_addr          (m1_addr),
    .m0_wr_data       (m0_wr_data),
    .m1_wr_data       (m1_wr_data),
    .m0_wr_mask       (m0_wr_mask),
    .m1_wr_mask       (m1_wr_mask),
    .m0_grant         (m0_grant),
    .m1_grant         (m1_grant),
    .m0_wr_ack        (m0_wr_ack),
    .m1_wr_ack        (m1_wr_ack),
    .m0_rd_valid      (m0_rd_valid),
    .m1_rd_valid      (m1_rd_valid),
    .rd_data          (rd_data),
    .m0_done          (m0_done),
    .m1_done          (m1_done),
    .rd_timeout       (rd_timeout),
    .br_cmd           (br_cmd),
    .br_cmd_en        (br_cmd_en),
    .br_addr          (br_addr),
    .br_wr_data       (br_wr_data),
    .br_data_mask     (br_data_mask),
    .br_rd_data       (br_rd_data),
    .br_rd_data_valid (br_rd_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_grant(input string tag, input int port, input int limit, output int gcyc);
    gcyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((port == 0 && m0_grant) || (port == 1 && m1_grant)) begin
        gcyc = cyc;
        break;
      end
    end
    check(tag, 64'(gcyc >= 0), 64'd1);
  endtask

  // Requester write-data model: steps to the next beat as soon as it sees wr_ack.
  initial begin
    k0 = 0;
    k1 = 0;
    forever begin
      @(posedge clk);
      #2;
      k0 = m0_wr_ack ? (m0_grant ? 1 : k0 + 1) : 0;
      k1 = m1_wr_ack ? (m1_grant ? 1 : k1 + 1) : 0;
      m0_wr_data = base0 + 64'(k0);
      m1_wr_data = base1 + 64'(k1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   g, g2, ncmd, n0, n1, both;
    logic rv;
    logic [3:0] ord;
    logic [3:0] ord_exp;

    rst = 1'b1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0;
    base0 = '0; base1 = '0;
    m0_wr_data = '0; m1_wr_data = '0;
    m0_wr_mask = 8'h0F; m1_wr_mask = 8'h00;
    br_rd_data = 64'hDEAD; br_rd_data_valid = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_en", 64'(br_cmd_en), 0);
    check("rst_cmd", 64'(br_cmd), 0);
    check("rst_addr", 64'(br_addr), 0);
    check("rst_wdata", br_wr_data, 0);
    check("rst_mask", 64'(br_data_mask), 0);
    check("rst_pulses", 64'({m0_grant, m1_grant, m0_wr_ack, m1_wr_ack, m0_done, m1_done, rd_timeout}), 0);
    check("rst_rd_valid", 64'({m0_rd_valid, m1_rd_valid}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_rd_valid_ignored", 64'({m0_rd_valid, m1_rd_valid}), 0);
    check("rd_data_pass", rd_data, 64'hDEAD);
    @(posedge clk); #1;
    br_rd_data_valid = 1'b0;

    // T1: m0 read, beats at cmd+10..13
    @(posedge clk); #1;
    m0_we = 0; m0_addr = 21'h000100; m0_req = 1;
    wait_grant("t1_grant", 0, 10, g);
    check("t1_cmd_en", 64'(br_cmd_en), 1);
    check("t1_cmd", 64'(br_cmd), 0);
    check("t1_addr", 64'(br_addr), 64'h100);
    check("t1_m1_grant", 64'(m1_grant), 0);
    ncmd = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      m0_req = 0;
      rv = (cyc >= g + 10 && cyc <= g + 13);
      br_rd_data_valid = rv;
      br_rd_data = 64'hB000 + 64'(cyc - g);
      @(negedge clk);
      check("t1_rd_valid", 64'(m0_rd_valid), 64'(rv));
      check("t1_m1_rd_valid", 64'(m1_rd_valid), 0);
      if (rv) check("t1_rd_data", rd_data, 64'hB000 + 64'(cyc - g));
      check("t1_done", 64'(m0_done), 64'(cyc == g + 14));
      ncmd += int'(br_cmd_en);
    end
    check("t1_single_cmd", 64'(ncmd), 0);
    repeat (12) @(posedge clk);

    // T2: m1 write A..D, held request gives a back-to-back second burst
    #1;
    base1 = 64'hA; m1_we = 1; m1_addr = 21'h1FFFE0; m1_req = 1;
    wait_grant("t2_grant", 1, 10, g);
    check("t2_cmd_en", 64'(br_cmd_en), 1);
    check("t2_cmd", 64'(br_cmd), 1);
    check("t2_addr", 64'(br_addr), 64'h1FFFE0);
    check("t2_mask", 64'(br_data_mask), 0);
    for (int i = 0; i <= 4; i++) begin
      if (i != 0) @(negedge clk);
      check("t2_ack", 64'(m1_wr_ack), 64'(i < 4));
      check("t2_m0_ack", 64'(m0_wr_ack), 0);
      if (i < 4) check("t2_wdata", br_wr_data, 64'hA + 64'(i));
      check("t2_done", 64'(m1_done), 64'(i == 3));
    end
    wait_grant("t2_regrant", 1, 30, g2);
    check("t2_spacing", 64'((g2 - g) >= 13), 1);
    @(posedge clk); #1;
    m1_req = 0;
    repeat (20) @(posedge clk);

    // T3: both request twice each
    #1;
    base0 = 64'h100; base1 = 64'h200;
    m0_we = 1; m1_we = 1; m0_addr = 21'h000200; m1_addr = 21'h000300;
    n0 = 0; n1 = 0; both = 0; ord = '0;
    for (int i = 0; i < 120 && (n0 + n1) < 4; i++) begin
      @(posedge clk); #1;
      m0_req = (n0 < 2);
      m1_req = (n1 < 2);
      @(negedge clk);
      if (m0_grant && m1_grant) both++;
      if (m0_grant || m1_grant) ord = {ord[2:0], m1_grant};
      if (m0_grant) n0++;
      if (m1_grant) n1++;
    end
`ifdef BR_ARBITER_ROUND_ROBIN_EN
    ord_exp = 4'b0101;
`else
    ord_exp = 4'b0011;
`endif
    check("t3_grant_count", 64'(n0 + n1), 4);
    check("t3_never_both", 64'(both), 0);
    check("t3_order", 64'(ord), 64'(ord_exp));
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
    repeat (20) @(posedge clk);

    // T4: read with 2 beats only, then a stray beat in GAP
    #1;
    m0_we = 0; m0_addr = 21'h000040; m0_req = 1;
    wait_grant("t4_grant", 0, 10, g);
    for (int i = 1; i <= 70; i++) begin
      @(posedge clk); #1;
      m0_req = 0;
      rv = (cyc == g + 5 || cyc == g + 6 || cyc == g + 66);
      br_rd_data_valid = rv;
      @(negedge clk);
      check("t4_rd_valid", 64'(m0_rd_valid), 64'(rv && cyc < g + 64));
      check("t4_timeout", 64'(rd_timeout), 64'(cyc == g + 64));
      check("t4_done", 64'(m0_done), 64'(cyc == g + 64));
    end
    @(posedge clk); #1;
    br_rd_data_valid = 0;
    repeat (12) @(posedge clk);

    // T5: async reset in the middle of a write burst
    #1;
    base0 = 64'h50; m0_we = 1; m0_addr = 21'h000080; m0_req = 1;
    wait_grant("t5_grant", 0, 10, g);
    @(posedge clk); #1;
    m0_req = 0;
    @(posedge clk); #2;
    check("t5_beat2", br_wr_data, 64'h52);
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_cmd_en", 64'(br_cmd_en), 0);
    check("t5_rst_wdata", br_wr_data, 0);
    check("t5_rst_addr", 64'(br_addr), 0);
    check("t5_rst_pulses", 64'({m0_grant, m0_wr_ack, m0_done, br_cmd, br_data_mask}), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ncmd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ncmd += int'(m0_done) + int'(m0_wr_ack) + int'(br_cmd_en);
    end
    check("t5_quiet_after_rst", 64'(ncmd), 0);
    @(posedge clk); #1;
    m0_we = 0; m0_addr = 21'h000123; m0_req = 1;
    wait_grant("t5_new_grant", 0, 10, g);
    check("t5_new_cmd_en", 64'(br_cmd_en), 1);
    check("t5_new_cmd", 64'(br_cmd), 0);
    check("t5_new_addr", 64'(br_addr), 64'h123);
    @(posedge clk); #1;
    m0_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
